// File: rtl/vis_morph3x3.sv
// vis_morph3x3: RGB -> luma -> threshold, then 3x3 binary erosion/dilation over a
//   two-line window built from clock-counted line delays (H_TOTAL clocks per line).
// Latency: H_TOTAL+3 clocks on every output bit, all modes, blanking included.
// Backpressure: none; one pixel accepted per clock unconditionally.
// Ports: clk, rst_n (synchronous, active-low); sw[2:0] mode select (0 pass,
//   1 binary, 2 erode, 3 dilate, 4-7 pass), latched at the out_vsync rise;
//   in_de/in_hsync/in_vsync + in_red/green/blue video in; out_* same set, delayed.
module vis_morph3x3 #(
  parameter int H_TOTAL = 1650,
  parameter int THRESH  = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic       in_de,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic [7:0] in_red,
  input  logic [7:0] in_green,
  input  logic [7:0] in_blue,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [7:0] out_red,
  output logic [7:0] out_green,
  output logic [7:0] out_blue
);

  localparam int LAT   = H_TOTAL + 3;
  // A RAM of DEPTH words read-before-write plus its output register gives a
  // delay of exactly H_TOTAL clocks.
  localparam int DEPTH = H_TOTAL - 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(LAT + 1);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } side_t;

  typedef struct packed {
    logic de;
    logic bin;
  } tap_t;

  // Centre-row word: the window tap plus the sync/RGB that travels with it.
  typedef struct packed {
    side_t side;
    tap_t  tap;
  } ctr_t;

  // ---------------------------------------------------------------- stage 1
  logic [7:0] luma;
  assign luma = 8'((16'(in_red) * 16'd77 + 16'(in_green) * 16'd150
                  + 16'(in_blue) * 16'd29) >> 8);

  ctr_t p1;
  always_ff @(posedge clk) begin
    p1.tap.de  <= in_de;
    p1.tap.bin <= (luma >= 8'(THRESH));
    p1.side    <= {in_hsync, in_vsync, in_red, in_green, in_blue};
  end

  // ---------------------------------------------------------- line delays
  // Not reset: stale contents after reset are hidden by the warm-up mask.
  ctr_t          lb1_mem [DEPTH];
  tap_t          lb2_mem [DEPTH];
  ctr_t          lb1_q;
  tap_t          lb2_q;
  logic [PW-1:0] ptr;

  always_ff @(posedge clk) begin
    lb1_mem[ptr] <= p1;
    lb1_q        <= lb1_mem[ptr];
    lb2_mem[ptr] <= lb1_q.tap;
    lb2_q        <= lb2_mem[ptr];
  end

  // ---------------------------------------------------------- 3x3 window
  // Each row's newest tap is its source register; two more registers give
  // the other two columns. Centre = p1 delayed H_TOTAL+1.
  tap_t w0_1, w0_2, w1_2, w2_1, w2_2;
  ctr_t ctr;
  logic vs_d;

  always_ff @(posedge clk) begin
    w0_1 <= p1.tap;
    w0_2 <= w0_1;
    ctr  <= lb1_q;
    w1_2 <= ctr.tap;
    w2_1 <= lb2_q;
    w2_2 <= w2_1;
    vs_d <= ctr.side.vs;
  end

  tap_t [8:0] taps;
  logic       all_set;
  logic       any_set;

  // A tap outside active video is neutral: 1 for the AND, 0 for the OR, so
  // frame edges are neither eaten away nor grown.
  always_comb begin
    taps    = {p1.tap, w0_1, w0_2, lb1_q.tap, ctr.tap, w1_2, lb2_q, w2_1, w2_2};
    all_set = 1'b1;
    any_set = 1'b0;
    for (int i = 0; i < 9; i++) begin
      all_set = all_set & (taps[i].bin | ~taps[i].de);
      any_set = any_set | (taps[i].bin & taps[i].de);
    end
  end

  // ------------------------------------------------------------ output mux
  logic [2:0]  mode_r;
  logic [23:0] rgb_nxt;

  always_comb begin
    rgb_nxt = {ctr.side.r, ctr.side.g, ctr.side.b};
    case (mode_r)
      3'd1:    rgb_nxt = {24{ctr.tap.bin}};
      3'd2:    rgb_nxt = {24{all_set}};
      3'd3:    rgb_nxt = {24{any_set}};
      default: ;
    endcase
    if (!ctr.tap.de) rgb_nxt = '0;
  end

  // ---------------------------------------------------------- control/out
  // warm_cnt counts LAT clocks after reset release; until then every output
  // is held at 0, which covers stale RAM and pointer re-alignment.
  logic [CW-1:0] warm_cnt;
  logic          warm;
  assign warm = (warm_cnt == CW'(LAT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      warm_cnt  <= '0;
      mode_r    <= '0;
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_red   <= '0;
      out_green <= '0;
      out_blue  <= '0;
    end else begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
      if (!warm) warm_cnt <= warm_cnt + CW'(1);
      // Mode changes only on the out_vsync rise, so a frame never mixes modes.
      if (warm && ctr.side.vs && !vs_d) mode_r <= sw;
      if (warm) begin
        out_de    <= ctr.tap.de;
        out_hsync <= ctr.side.hs;
        out_vsync <= ctr.side.vs;
        out_red   <= rgb_nxt[23:16];
        out_green <= rgb_nxt[15:8];
        out_blue  <= rgb_nxt[7:0];
      end else begin
        out_de    <= 1'b0;
        out_hsync <= 1'b0;
        out_vsync <= 1'b0;
        out_red   <= '0;
        out_green <= '0;
        out_blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vis_morph3x3.sv
// tb_vis_morph3x3: drives 16-clock lines (8 active px), 12-line frames
//   (vsync lines 0-1, active lines 3-10); expected words queued at drive time
//   and popped LAT clocks later against {de,hs,vs,R,G,B}.
module tb_vis_morph3x3;

  localparam int H   = 16;
  localparam int LAT = H + 3;
  localparam int NL  = 12;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  logic       in_de, in_hsync, in_vsync;
  logic [7:0] in_red, in_green, in_blue;
  logic       out_de, out_hsync, out_vsync;
  logic [7:0] out_red, out_green, out_blue;

  vis_morph3x3 #(.H_TOTAL(H), .THRESH(128)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .in_de     (in_de),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .in_red    (in_red),
    .in_green  (in_green),
    .in_blue   (in_blue),
    .out_de    (out_de),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_red   (out_red),
    .out_green (out_green),
    .out_blue  (out_blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] img [8][8];
  logic [26:0] sb [$];
  logic [2:0]  model_mode;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          blank_until = LAT + 2;

  task automatic chk(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit bin_of(input logic [23:0] c);
    int y;
    y = (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) >> 8;
    return (y >= 128);
  endfunction

  function automatic bit tap(input int ln, input int x, input bit neutral);
    if (ln >= 3 && ln <= 10 && x >= 0 && x <= 7) return bin_of(img[ln-3][x]);
    return neutral;
  endfunction

  function automatic logic [23:0] in_rgb(input int ln, input int p);
    if (ln >= 3 && ln <= 10 && p < 8) return img[ln-3][p];
    return 24'hA5A55A;
  endfunction

  function automatic logic [26:0] exp_word(input int ln, input int p);
    logic        de, hs, vs;
    logic [23:0] rgb;
    bit          a, o;
    de  = (ln >= 3 && ln <= 10 && p < 8);
    hs  = (p == 10 || p == 11);
    vs  = (ln < 2);
    rgb = '0;
    if (de) begin
      case (model_mode)
        3'd1: rgb = tap(ln, p, 1'b0) ? 24'hFFFFFF : 24'h000000;
        3'd2, 3'd3: begin
          a = 1'b1;
          o = 1'b0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
              a &= tap(ln + dy, p + dx, 1'b1);
              o |= tap(ln + dy, p + dx, 1'b0);
            end
          rgb = ((model_mode == 3'd2) ? a : o) ? 24'hFFFFFF : 24'h000000;
        end
        default: rgb = img[ln-3][p];
      endcase
    end
    return {de, hs, vs, rgb};
  endfunction

  task automatic step(input logic r, input logic de, input logic hs, input logic vs,
                      input logic [23:0] rgb, input logic [26:0] e, input string tag);
    logic [26:0] f;
    bit          have;
    @(posedge clk);
    cyc++;
    #1;
    rst_n    = r;
    in_de    = de;
    in_hsync = hs;
    in_vsync = vs;
    {in_red, in_green, in_blue} = rgb;
    sb.push_back(e);
    @(negedge clk);
    have = 0;
    f    = '0;
    if (sb.size() > LAT) begin
      f    = sb.pop_front();
      have = 1;
    end
    if (cyc <= blank_until) begin
      f    = '0;
      have = 1;
    end
    if (have) chk(tag, {out_de, out_hsync, out_vsync, out_red, out_green, out_blue}, f);
    if (!r) blank_until = cyc + LAT + 1;
  endtask

  task automatic run_frame(input string tag, input int chg_line, input logic [2:0] chg_sw,
                           input int rst_line, input int rst_pos);
    logic r;
    for (int ln = 0; ln < NL; ln++)
      for (int p = 0; p < H; p++) begin
        if (ln == chg_line && p == 0) sw = chg_sw;
        if (ln == 0 && p == 0) model_mode = sw;
        r = !(ln == rst_line && (p == rst_pos || p == rst_pos + 1));
        step(r, (ln >= 3 && ln <= 10 && p < 8), (p == 10 || p == 11), (ln < 2),
             in_rgb(ln, p), exp_word(ln, p), tag);
        if (!r) model_mode = 3'd0;
      end
  endtask

  task automatic fill(input logic [23:0] c);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = c;
  endtask

  task automatic put_block();
    fill(24'h000000);
    for (int y = 2; y <= 4; y++)
      for (int x = 2; x <= 4; x++) img[y][x] = 24'hFFFFFF;
  endtask

  initial begin
    rst_n = 1'b0;
    sw = 3'd0;
    in_de = 1'b0;
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    in_red = '0;
    in_green = '0;
    in_blue = '0;
    model_mode = 3'd0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 27'h0, "reset");
    repeat (H) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 27'h0, "idle");

    // pass-through ramp
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = {3{8'(y * 8 + x + 1)}};
    sw = 3'd0;
    run_frame("pass", -1, 3'd0, -1, 0);

    // threshold boundary 128 / 127
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = ((x + y) % 2 == 0) ? 24'h808080 : 24'h7F7F7F;
    sw = 3'd1;
    run_frame("bin", -1, 3'd0, -1, 0);

    // erosion: lone dot vanishes, 3x3 block shrinks to its centre
    fill(24'h000000);
    img[3][3] = 24'hFFFFFF;
    sw = 3'd2;
    run_frame("ero_dot", -1, 3'd0, -1, 0);
    put_block();
    run_frame("ero_blk", -1, 3'd0, -1, 0);

    // dilation of a lone dot, then full-white erosion keeps its edges
    fill(24'h000000);
    img[3][3] = 24'hFFFFFF;
    sw = 3'd3;
    run_frame("dil_dot", -1, 3'd0, -1, 0);
    fill(24'hFFFFFF);
    sw = 3'd2;
    run_frame("ero_full", -1, 3'd0, -1, 0);

    // mid-frame switch change only affects the next frame
    put_block();
    sw = 3'd2;
    run_frame("sw_mid", 6, 3'd3, -1, 0);
    run_frame("sw_next", -1, 3'd0, -1, 0);

    // reset mid-line, then clean recovery
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[y][x] = 24'($urandom);
    sw = 3'd2;
    run_frame("rst", -1, 3'd0, 6, 3);
    run_frame("post_rst", -1, 3'd0, -1, 0);
    sw = 3'd3;
    run_frame("rand_dil", -1, 3'd0, -1, 0);
    sw = 3'd5;
    run_frame("mode5", -1, 3'd0, -1, 0);

    repeat (LAT + 2) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 27'h0, "flush");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
